// File: rtl/uart_pkt_ctrl.sv
//==========================================================================
// Module   : uart_pkt_ctrl
// Brief    : Receives a framed UART packet into a buffer RAM, hands it to a
//            processing engine, then transmits the processed buffer back.
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module uart_pkt_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              busy,
    output logic              pkt_ok,
    output logic              pkt_err
);

    localparam int              c_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMAX    = c_TW'(TIMEOUT - 1);
    localparam logic [16:0]     c_MAX_LEN = 17'(2 ** ADDR_W);
    localparam logic [7:0]      c_SYNC    = 8'hA5;
    localparam logic [7:0]      c_NAK     = 8'h15;

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_HDR_H   = 4'd1;
    localparam logic [3:0] c_HDR_L   = 4'd2;
    localparam logic [3:0] c_PAYLOAD = 4'd3;
    localparam logic [3:0] c_CHK     = 4'd4;
    localparam logic [3:0] c_PROC    = 4'd5;
    localparam logic [3:0] c_TX_SYNC = 4'd6;
    localparam logic [3:0] c_TX_LH   = 4'd7;
    localparam logic [3:0] c_TX_LL   = 4'd8;
    localparam logic [3:0] c_TX_RD   = 4'd9;
    localparam logic [3:0] c_TX_CAP  = 4'd10;
    localparam logic [3:0] c_TX_WR   = 4'd11;
    localparam logic [3:0] c_TX_CHK  = 4'd12;
    localparam logic [3:0] c_TX_NAK  = 4'd13;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [16:0]       r_len;
    logic [16:0]       r_idx;
    logic [7:0]        r_sum;
    logic [7:0]        r_byte;
    logic [c_TW-1:0]   r_tcnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic              r_proc_start;
    logic              w_rx_wait;
    logic [16:0]       w_len_rx;
    logic [16:0]       w_idx_inc;

    assign w_rx_wait  = (r_state == c_HDR_H) || (r_state == c_HDR_L) ||
                        (r_state == c_PAYLOAD) || (r_state == c_CHK);
    assign w_len_rx   = {1'b0, r_len[15:8], r_data};
    assign w_idx_inc  = r_idx + 17'd1;

    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_wdata;
    // The read address is only presented in TX_RD; elsewhere the last write address is held.
    assign mem_addr   = (r_state == c_TX_RD) ? r_idx[ADDR_W-1:0] : r_waddr;
    assign proc_start = r_proc_start;
    assign busy       = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        pkt_ok  = 1'b0;
        pkt_err = 1'b0;
        case (r_state)
            c_IDLE: if (!rx_empty) begin
                rd_uart = 1'b1;
                if (r_data == c_SYNC) w_next = c_HDR_H;
            end
            c_HDR_H: if (!rx_empty) begin
                rd_uart = 1'b1;
                w_next  = c_HDR_L;
            end
            c_HDR_L: if (!rx_empty) begin
                rd_uart = 1'b1;
                w_next  = ((w_len_rx == '0) || (w_len_rx > c_MAX_LEN)) ? c_TX_NAK : c_PAYLOAD;
            end
            c_PAYLOAD: if (!rx_empty) begin
                rd_uart = 1'b1;
                if (w_idx_inc == r_len) w_next = c_CHK;
            end
            c_CHK: if (!rx_empty) begin
                rd_uart = 1'b1;
                w_next  = (r_data == r_sum) ? c_PROC : c_TX_NAK;
            end
            c_PROC: if (proc_done) w_next = c_TX_SYNC;
            c_TX_SYNC: begin
                w_data  = c_SYNC;
                wr_uart = !tx_full;
                if (!tx_full) w_next = c_TX_LH;
            end
            c_TX_LH: begin
                w_data  = r_len[15:8];
                wr_uart = !tx_full;
                if (!tx_full) w_next = c_TX_LL;
            end
            c_TX_LL: begin
                w_data  = r_len[7:0];
                wr_uart = !tx_full;
                if (!tx_full) w_next = c_TX_RD;
            end
            c_TX_RD:  w_next = c_TX_CAP;
            c_TX_CAP: w_next = c_TX_WR;
            c_TX_WR: begin
                w_data  = r_byte;
                wr_uart = !tx_full;
                if (!tx_full) w_next = (w_idx_inc == r_len) ? c_TX_CHK : c_TX_RD;
            end
            c_TX_CHK: begin
                w_data  = r_sum;
                wr_uart = !tx_full;
                pkt_ok  = !tx_full;
                if (!tx_full) w_next = c_IDLE;
            end
            c_TX_NAK: begin
                w_data  = c_NAK;
                wr_uart = !tx_full;
                pkt_err = !tx_full;
                if (!tx_full) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
        // A byte present on the expiry cycle wins over the timeout.
        if (w_rx_wait && rx_empty && (r_tcnt == c_TMAX)) begin
            w_next  = c_IDLE;
            pkt_err = 1'b1;
        end
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
            pkt_ok  = 1'b0;
            pkt_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_idx        <= '0;
            r_sum        <= '0;
            r_byte       <= '0;
            r_tcnt       <= '0;
            r_mem_we     <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_proc_start <= 1'b0;
        end else begin
            r_mem_we     <= 1'b0;
            r_proc_start <= 1'b0;
            if (w_rx_wait && !rd_uart) r_tcnt <= r_tcnt + 1'b1;
            else                       r_tcnt <= '0;
            case (r_state)
                c_HDR_H: if (rd_uart) r_len <= {1'b0, r_data, 8'h00};
                c_HDR_L: if (rd_uart) begin
                    r_len <= w_len_rx;
                    r_idx <= '0;
                    r_sum <= '0;
                end
                c_PAYLOAD: if (rd_uart) begin
                    r_mem_we <= 1'b1;
                    r_waddr  <= r_idx[ADDR_W-1:0];
                    r_wdata  <= r_data;
                    r_idx    <= w_idx_inc;
                    r_sum    <= r_sum + r_data;
                end
                c_CHK: if (rd_uart && (r_data == r_sum)) r_proc_start <= 1'b1;
                c_TX_LL: if (wr_uart) begin
                    r_idx <= '0;
                    r_sum <= '0;
                end
                c_TX_CAP: r_byte <= mem_rdata;
                c_TX_WR: if (wr_uart) begin
                    r_sum <= r_sum + r_byte;
                    r_idx <= w_idx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_pkt_ctrl.sv
//==========================================================================
// Module   : tb_uart_pkt_ctrl
// Brief    : Self-checking bench for uart_pkt_ctrl with FIFO/RAM/engine models.
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module tb_uart_pkt_ctrl;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 40;
    localparam int MAXLEN  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              proc_start;
    logic              proc_done;
    logic              busy;
    logic              pkt_ok;
    logic              pkt_err;

    always #5 clk = ~clk;

    uart_pkt_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .proc_start(proc_start), .proc_done(proc_done), .busy(busy),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err)
    );

    int                  n_tests  = 0;
    int                  n_fail   = 0;
    int                  n_start  = 0;
    int                  n_ok     = 0;
    int                  n_err    = 0;
    int                  proc_len = 0;
    int                  slow_gap = -1;
    logic [7:0]          mem [MAXLEN];
    logic [7:0]          txq [$];
    logic [ADDR_W+7:0]   wlog [$];
    logic [7:0]          pay [$];

    // Environment: transmit FIFO sink, buffer RAM and a +1-per-byte processing engine.
    always @(posedge clk) begin
        if (wr_uart) txq.push_back(w_data);
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= mem[mem_addr];
        if (proc_done)
            for (int i = 0; i < proc_len; i++) mem[i] <= mem[i] + 8'd1;
        if (proc_start) n_start++;
        if (pkt_ok)     n_ok++;
        if (pkt_err)    n_err++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, rd_uart, wr_uart, mem_we, proc_start, pkt_ok, pkt_err,
                    w_data, mem_addr, mem_wdata});
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_empty = 1'b0;
        r_data   = b;
        #1;
        n = 0;
        while (!rd_uart && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rd_uart) check("rx_pop_wait", 32'(rd_uart), 32'd1);
        @(posedge clk);
        #1 rx_empty = 1'b1;
    endtask

    function automatic int rgap();
        return int'($urandom_range(0, 3));
    endfunction

    task automatic fill_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    // mode 0: random backpressure, 1: 50-cycle stall on first payload push, 2: reset in TX_RD
    task automatic run_packet(input int len, input bit bad_chk, input int mode);
        logic [7:0]  exp_tx [$];
        logic [7:0]  csum, psum, b, wd;
        logic [15:0] l16;
        int          tx_base, w_base, s0, o0, e0, n, bad, exp_start;
        bit          valid_len, did_reset, stalled;
        l16       = 16'(len);
        valid_len = (len > 0) && (len <= MAXLEN);
        csum      = 8'h00;
        psum      = 8'h00;
        wd        = 8'h00;
        if (valid_len) for (int i = 0; i < len; i++) csum += pay[i];
        if (!valid_len || bad_chk) begin
            exp_tx.push_back(8'h15);
        end else begin
            exp_tx.push_back(8'hA5);
            exp_tx.push_back(l16[15:8]);
            exp_tx.push_back(l16[7:0]);
            for (int i = 0; i < len; i++) begin
                b = pay[i] + 8'd1;
                exp_tx.push_back(b);
                psum += b;
            end
            exp_tx.push_back(psum);
        end
        exp_start = (exp_tx.size() > 1) ? 1 : 0;
        tx_base = txq.size();
        w_base  = wlog.size();
        s0 = n_start; o0 = n_ok; e0 = n_err;

        send_byte(8'hA5, rgap());
        send_byte(l16[15:8], rgap());
        send_byte(l16[7:0], rgap());
        if (valid_len) begin
            for (int i = 0; i < len; i++) send_byte(pay[i], rgap());
            send_byte(bad_chk ? csum + 8'd1 : csum, (slow_gap >= 0) ? slow_gap : rgap());
        end

        if (exp_start == 1) begin
            n = 0;
            while (n_start == s0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (int'($urandom_range(1, 6))) @(negedge clk);
            proc_len  = len;
            proc_done = 1'b1;
            @(negedge clk);
            proc_done = 1'b0;
        end

        n = 0; did_reset = 1'b0; stalled = 1'b0;
        while ((txq.size() - tx_base) < exp_tx.size() && n < 3000) begin
            @(negedge clk);
            n++;
            if (mode == 2 && (txq.size() - tx_base) == 3) begin
                tx_full = 1'b0;
                reset   = 1'b1;
                @(negedge clk);
                check("reset_in_tx_outputs", out_vec(), 32'd0);
                reset     = 1'b0;
                did_reset = 1'b1;
                break;
            end else if (mode == 1 && !stalled && (txq.size() - tx_base) == 3) begin
                stalled = 1'b1;
                bad     = 0;
                tx_full = 1'b1;
                for (int k = 0; k < 50; k++) begin
                    #1;
                    if (wr_uart) bad++;
                    if (k == 6) wd = w_data;
                    else if (k > 6 && w_data !== wd) bad++;
                    @(negedge clk);
                end
                tx_full = 1'b0;
                check("stall_push_or_wdata_change", 32'(bad), 32'd0);
                check("stall_wdata", 32'(wd), 32'(pay[0] + 8'd1));
            end else begin
                tx_full = ($urandom_range(0, 3) == 0);
            end
        end
        tx_full = 1'b0;

        if (did_reset) begin
            repeat (20) @(negedge clk);
            check("reset_in_tx_no_more_push", 32'(txq.size() - tx_base), 32'd3);
            check("reset_in_tx_idle", 32'(busy), 32'd0);
            return;
        end

        repeat (5) @(negedge clk);
        check("tx_count", 32'(txq.size() - tx_base), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && (tx_base + i) < txq.size(); i++)
            check($sformatf("tx_byte%0d", i), 32'(txq[tx_base + i]), 32'(exp_tx[i]));
        check("proc_start_count", 32'(n_start - s0), 32'(exp_start));
        check("pkt_ok_count", 32'(n_ok - o0), 32'(exp_start));
        check("pkt_err_count", 32'(n_err - e0), 32'(1 - exp_start));
        check("busy_after_packet", 32'(busy), 32'd0);
        if (valid_len) begin
            check("ram_write_count", 32'(wlog.size() - w_base), 32'(len));
            for (int i = 0; i < len && (w_base + i) < wlog.size(); i++)
                check($sformatf("ram_write%0d", i), 32'(wlog[w_base + i]),
                      32'({ADDR_W'(i), pay[i]}));
        end
    endtask

    initial begin
        int tx_base, e0;
        reset     = 1'b1;
        rx_empty  = 1'b1;
        r_data    = 8'h00;
        tx_full   = 1'b0;
        proc_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reference packet and bad checksum
        pay = '{8'h01, 8'h02, 8'h03};
        run_packet(3, 1'b0, 0);
        pay = '{8'h10, 8'h20};
        run_packet(2, 1'b1, 0);

        // Garbage before a valid packet
        tx_base = txq.size();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        repeat (3) @(negedge clk);
        check("garbage_idle", 32'(busy), 32'd0);
        check("garbage_no_tx", 32'(txq.size() - tx_base), 32'd0);
        fill_pay(1);
        run_packet(1, 1'b0, 0);

        // Inter-byte timeout, then recovery
        tx_base = txq.size();
        e0      = n_err;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h31, 0);
        send_byte(8'h32, 0);
        repeat (TIMEOUT - 2) @(negedge clk);
        check("timeout_not_early_busy", 32'(busy), 32'd1);
        check("timeout_not_early_err", 32'(n_err - e0), 32'd0);
        repeat (12) @(negedge clk);
        check("timeout_err", 32'(n_err - e0), 32'd1);
        check("timeout_no_tx", 32'(txq.size() - tx_base), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        fill_pay(2);
        run_packet(2, 1'b0, 0);

        // Byte arriving exactly on the expiry cycle is accepted
        fill_pay(3);
        slow_gap = TIMEOUT - 1;
        run_packet(3, 1'b0, 0);
        slow_gap = -1;

        // Transmit backpressure held for 50 cycles
        fill_pay(5);
        run_packet(5, 1'b0, 1);

        // Length boundaries
        fill_pay(MAXLEN);
        run_packet(MAXLEN, 1'b0, 0);
        run_packet(MAXLEN + 1, 1'b0, 0);
        run_packet(0, 1'b0, 0);

        // Reset in PAYLOAD
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_payload_outputs", out_vec(), 32'd0);
        reset = 1'b0;
        fill_pay(4);
        run_packet(4, 1'b0, 0);

        // Reset in TX_RD
        fill_pay(4);
        run_packet(4, 1'b0, 2);
        fill_pay(3);
        run_packet(3, 1'b0, 0);

        // Randomized packets
        for (int p = 0; p < 8; p++) begin
            int len;
            len = int'($urandom_range(1, MAXLEN));
            fill_pay(len);
            run_packet(len, ($urandom_range(0, 4) == 0), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_pkt_ctrl.md
UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: buffer address width; max payload 2^ADDR_W bytes.
REQ-002 Parameter TIMEOUT, default 5_000_000: inter-byte receive timeout in clk cycles.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_empty  in  1  UART receive FIFO empty; r_data is valid whenever rx_empty=0 (first-word-fall-through).
REQ-006 r_data  in  8  head byte of the receive FIFO.
REQ-007 rd_uart  out  1  one-cycle pop of the receive FIFO.
REQ-008 tx_full  in  1  UART transmit FIFO full.
REQ-009 wr_uart  out  1  one-cycle push of w_data into the transmit FIFO.
REQ-010 w_data  out  8  byte to transmit.
REQ-011 mem_we, mem_addr[ADDR_W-1:0], mem_wdata[7:0]  out  buffer RAM write/read port.
REQ-012 mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr (synchronous read).
REQ-013 proc_start  out  1  one-cycle pulse: buffer filled, start processing.
REQ-014 proc_done  in  1  one-cycle pulse: processing finished, buffer holds result.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 pkt_ok, pkt_err  out  1  one-cycle status pulses.

Function
REQ-017 Packet format: 0xA5, LEN_H, LEN_L, LEN payload bytes, CHK; CHK = 8-bit modulo-256 sum of payload bytes.
REQ-018 A byte is consumed only in a cycle where rx_empty=0; rd_uart=1 in that same cycle; at most one pop per cycle; no pop in states other than IDLE, HDR_H, HDR_L, PAYLOAD, CHK.
REQ-019 A byte is pushed only in a cycle where tx_full=0; wr_uart=1 with w_data stable that cycle; when tx_full=1 the controller holds state and byte.
REQ-020 States: IDLE, HDR_H, HDR_L, PAYLOAD, CHK, PROC, TX_SYNC, TX_LH, TX_LL, TX_RD, TX_CAP, TX_WR, TX_CHK, TX_NAK.
REQ-021 IDLE: consume bytes; 0xA5 -> HDR_H; any other byte discarded, remain IDLE.
REQ-022 HDR_H/HDR_L: capture LEN[15:8]/LEN[7:0]; after LEN_L, LEN=0 or LEN>2^ADDR_W -> TX_NAK, else clear index and sum, -> PAYLOAD.
REQ-023 PAYLOAD: per consumed byte, in the next cycle mem_we=1, mem_addr=index, mem_wdata=byte; index+1; sum+=byte; after byte LEN -> CHK.
REQ-024 CHK: consume one byte; equal to sum -> PROC with proc_start pulsed on entry; unequal -> TX_NAK.
REQ-025 PROC: wait for proc_done, no timeout; on proc_done -> TX_SYNC; proc_done outside PROC ignored.
REQ-026 TX_SYNC/TX_LH/TX_LL push 0xA5, LEN_H, LEN_L; clear index and sum; -> TX_RD.
REQ-027 TX_RD drives mem_addr=index; TX_CAP latches mem_rdata into byte register; TX_WR pushes it, sum+=byte, index+1; -> TX_RD until LEN bytes sent, then TX_CHK.
REQ-028 TX_CHK pushes sum; pkt_ok pulses the cycle of the push; -> IDLE.
REQ-029 TX_NAK pushes 0x15; pkt_err pulses the cycle of the push; -> IDLE.
REQ-030 Timeout: counter cleared on every consumed byte and on entry to HDR_H; in HDR_H, HDR_L, PAYLOAD, CHK, reaching TIMEOUT cycles without a byte -> IDLE, pkt_err pulse, no NAK sent; counter idle in other states.
REQ-031 Byte arriving the same cycle the timeout expires is consumed normally; timeout does not fire.
REQ-032 index and LEN are 17 bits wide internally so LEN=2^ADDR_W does not wrap; mem_addr is index[ADDR_W-1:0].
REQ-033 mem_we is 0 in every state except the write cycle of REQ-023.

Reset
REQ-034 reset=1 at any clock edge -> IDLE; rd_uart, wr_uart, mem_we, proc_start, pkt_ok, pkt_err, busy = 0; w_data, mem_addr, mem_wdata = 0; LEN, index, sum, timeout counter = 0; a partial packet is discarded.
REQ-035 Reset mid-TX: no further pushes after the reset edge; bytes already in the UART FIFO are not recalled.

Verification
REQ-036 Packet A5 00 03 01 02 03 06, processing model +1 per byte -> RAM writes 0..2 = 01,02,03; one proc_start; TX A5 00 03 02 03 04 09; one pkt_ok.
REQ-037 Bad checksum A5 00 02 10 20 31 -> no proc_start; TX 15 only; one pkt_err; busy low afterwards.
REQ-038 Garbage 00 FF 5A then a valid packet of LEN=1 -> garbage discarded; valid packet processed normally.
REQ-039 A5 00 04 then 2 bytes, then silence for TIMEOUT cycles -> pkt_err, nothing transmitted, IDLE; next valid packet accepted.
REQ-040 tx_full held high 50 cycles during TX_WR -> wr_uart stays 0, w_data stable; transmission resumes byte-exact on release.
REQ-041 Reset asserted in PAYLOAD and in TX_RD -> all outputs at reset values next cycle; subsequent packet correct.
